// File: rtl/ucsbece154b_bpred_gshare_ras_pkg.sv
// Shared branch-type encoding, PHT reset value and the 2-bit counter update
// used by the gshare/RAS fetch predictor.
package ucsbece154b_bpred_gshare_ras_pkg;

    typedef enum logic [1:0] {
        BR_COND = 2'd0,
        BR_JUMP = 2'd1,
        BR_CALL = 2'd2,
        BR_RET  = 2'd3
    } br_type_t;

    localparam logic [1:0] PHT_RESET = 2'b01;

    // Saturating 2-bit direction counter: clamps at 2'b00 and 2'b11.
    function automatic logic [1:0] pht_next(input logic [1:0] ctr, input logic taken);
        if (taken) pht_next = (ctr == 2'b11) ? ctr : ctr + 2'b01;
        else       pht_next = (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/ucsbece154b_bpred_gshare_ras_if.sv
// Fetch-lookup and execute-update bundle between the pipeline (master)
// and the branch predictor (slave).
interface ucsbece154b_bpred_gshare_ras_if
    import ucsbece154b_bpred_gshare_ras_pkg::*;
#(
    parameter int NUM_GHR_BITS = 8,
    parameter int RAS_DEPTH    = 8
);
    localparam int PW = $clog2(RAS_DEPTH) + 1;

    logic                    f_valid_i;
    logic [31:0]             f_pc_i;
    logic                    f_taken_o;
    logic [31:0]             f_target_o;
    logic [NUM_GHR_BITS-1:0] f_ghr_o;
    logic [PW-1:0]           f_rasptr_o;

    logic                    u_valid_i;
    logic [31:0]             u_pc_i;
    br_type_t                u_type_i;
    logic                    u_taken_i;
    logic [31:0]             u_target_i;
    logic [NUM_GHR_BITS-1:0] u_ghr_i;
    logic [PW-1:0]           u_rasptr_i;
    logic                    u_mispredict_i;

    modport master (
        output f_valid_i, f_pc_i,
        output u_valid_i, u_pc_i, u_type_i, u_taken_i, u_target_i,
        output u_ghr_i, u_rasptr_i, u_mispredict_i,
        input  f_taken_o, f_target_o, f_ghr_o, f_rasptr_o
    );

    modport slave (
        input  f_valid_i, f_pc_i,
        input  u_valid_i, u_pc_i, u_type_i, u_taken_i, u_target_i,
        input  u_ghr_i, u_rasptr_i, u_mispredict_i,
        output f_taken_o, f_target_o, f_ghr_o, f_rasptr_o
    );

endinterface

// File: rtl/ucsbece154b_ras.sv
// Circular return-address stack with saturating occupancy pointer and
// checkpoint restore; on overflow the oldest entry is overwritten.
module ucsbece154b_ras #(
    parameter int RAS_DEPTH = 8,
    localparam int PW = $clog2(RAS_DEPTH) + 1,
    localparam int AW = $clog2(RAS_DEPTH)
) (
    input  logic          clk,
    input  logic          reset_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [31:0]   push_addr_i,
    input  logic          restore_i,
    input  logic [PW-1:0] restore_ptr_i,
    output logic [31:0]   top_o,
    output logic          empty_o,
    output logic [PW-1:0] ptr_o
);

    logic [31:0]   stack [RAS_DEPTH];
    logic [PW-1:0] ptr;
    // base tracks the oldest live slot; it only moves when a push overflows,
    // so with no overflow the slot index is simply ptr mod depth.
    logic [AW-1:0] base;

    logic [PW-1:0] base_ptr;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;
    logic          full_b;
    logic          empty_b;

    assign base_ptr = restore_i ? restore_ptr_i : ptr;
    assign wr_idx   = base + base_ptr[AW-1:0];
    assign top_idx  = base + ptr[AW-1:0] - 1'b1;
    assign full_b   = (base_ptr == PW'(RAS_DEPTH));
    assign empty_b  = (base_ptr == '0);

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            ptr  <= '0;
            base <= '0;
        end else if (push_i) begin
            if (full_b) begin
                base <= base + 1'b1;
                ptr  <= base_ptr;
            end else begin
                ptr  <= base_ptr + 1'b1;
            end
        end else if (pop_i) begin
            ptr <= empty_b ? base_ptr : base_ptr - 1'b1;
        end else begin
            ptr <= base_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) stack[wr_idx] <= push_addr_i;
    end

    assign top_o   = stack[top_idx];
    assign empty_o = (ptr == '0);
    assign ptr_o   = ptr;

endmodule

// File: rtl/ucsbece154b_bpred_gshare_ras.sv
// Fetch-stage predictor: tagged BTB with branch type, gshare/bimodal PHT,
// speculative GHR with checkpoint repair, and a return-address stack.
module ucsbece154b_bpred_gshare_ras
    import ucsbece154b_bpred_gshare_ras_pkg::*;
#(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 8,
    parameter int RAS_DEPTH       = 8,
    parameter int MODE            = 1
) (
    input  logic                          clk,
    input  logic                          reset_i,
    ucsbece154b_bpred_gshare_ras_if.slave bp
);

    localparam int IDX   = $clog2(NUM_BTB_ENTRIES);
    localparam int G     = NUM_GHR_BITS;
    localparam int TAG_W = 32 - IDX - 2;
    localparam int PHT_N = 2 ** G;
    localparam int PW    = $clog2(RAS_DEPTH) + 1;

    logic             btb_valid  [NUM_BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag    [NUM_BTB_ENTRIES];
    br_type_t         btb_type   [NUM_BTB_ENTRIES];
    logic [31:0]      btb_target [NUM_BTB_ENTRIES];
    logic [1:0]       pht        [PHT_N];
    logic [G-1:0]     ghr;

    function automatic logic [G-1:0] pht_index(input logic [31:0] pc, input logic [G-1:0] hist);
        pht_index = (MODE != 0) ? (pc[G+1:2] ^ hist) : pc[G+1:2];
    endfunction

    logic [IDX-1:0]   f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    br_type_t         f_type;
    logic             f_dir;
    logic             f_taken;
    logic [31:0]      f_target;
    logic [31:0]      ras_top;
    logic             ras_empty;
    logic [PW-1:0]    ras_ptr;

    assign f_idx  = bp.f_pc_i[IDX+1:2];
    assign f_tag  = bp.f_pc_i[31:IDX+2];
    assign f_hit  = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
    assign f_type = btb_type[f_idx];
    assign f_dir  = pht[pht_index(bp.f_pc_i, ghr)][1];

    always_comb begin
        f_taken  = 1'b0;
        f_target = '0;
        if (f_hit) begin
            case (f_type)
                BR_COND: begin
                    f_taken  = f_dir;
                    f_target = f_dir ? btb_target[f_idx] : '0;
                end
                BR_RET: begin
                    f_taken  = 1'b1;
                    f_target = ras_empty ? btb_target[f_idx] : ras_top;
                end
                default: begin
                    f_taken  = 1'b1;
                    f_target = btb_target[f_idx];
                end
            endcase
        end
    end

    logic           repair;
    logic           spec_en;
    logic [IDX-1:0] u_idx;
    logic [G-1:0]   u_pht_idx;
    logic           btb_wr;
    logic           pht_wr;

    // A resolving mispredict flushes fetch, so its speculative update is dropped.
    assign repair    = bp.u_valid_i && bp.u_mispredict_i;
    assign spec_en   = bp.f_valid_i && f_hit && !repair;
    assign u_idx     = bp.u_pc_i[IDX+1:2];
    assign u_pht_idx = pht_index(bp.u_pc_i, bp.u_ghr_i);
    assign btb_wr    = bp.u_valid_i && (bp.u_taken_i || (bp.u_type_i != BR_COND));
    assign pht_wr    = bp.u_valid_i && (bp.u_type_i == BR_COND);

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            for (int i = 0; i < NUM_BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
            for (int i = 0; i < PHT_N; i++)           pht[i]       <= PHT_RESET;
        end else begin
            if (btb_wr) btb_valid[u_idx]  <= 1'b1;
            if (pht_wr) pht[u_pht_idx]    <= pht_next(pht[u_pht_idx], bp.u_taken_i);
        end
    end

    always_ff @(posedge clk) begin
        if (btb_wr) begin
            btb_tag[u_idx]    <= bp.u_pc_i[31:IDX+2];
            btb_type[u_idx]   <= bp.u_type_i;
            btb_target[u_idx] <= bp.u_target_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            ghr <= '0;
        end else if (repair) begin
            ghr <= (bp.u_type_i == BR_COND) ? {bp.u_ghr_i[G-2:0], bp.u_taken_i} : bp.u_ghr_i;
        end else if (spec_en && (f_type == BR_COND)) begin
            ghr <= {ghr[G-2:0], f_dir};
        end
    end

    logic        ras_push;
    logic        ras_pop;
    logic [31:0] ras_addr;

    assign ras_push = repair ? (bp.u_type_i == BR_CALL) : (spec_en && (f_type == BR_CALL));
    assign ras_pop  = repair ? (bp.u_type_i == BR_RET)  : (spec_en && (f_type == BR_RET));
    assign ras_addr = repair ? (bp.u_pc_i + 32'd4) : (bp.f_pc_i + 32'd4);

    ucsbece154b_ras #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk           (clk),
        .reset_i       (reset_i),
        .push_i        (ras_push),
        .pop_i         (ras_pop),
        .push_addr_i   (ras_addr),
        .restore_i     (repair),
        .restore_ptr_i (bp.u_rasptr_i),
        .top_o         (ras_top),
        .empty_o       (ras_empty),
        .ptr_o         (ras_ptr)
    );

    assign bp.f_taken_o  = f_taken;
    assign bp.f_target_o = f_target;
    assign bp.f_ghr_o    = ghr;
    assign bp.f_rasptr_o = ras_ptr;

endmodule

// File: tb/tb_ucsbece154b_bpred_gshare_ras.sv
// Scoreboard bench: stimulus predicts each fetch response from a reference
// model and queues it; a negedge monitor compares every valid fetch.
module tb_ucsbece154b_bpred_gshare_ras;
    import ucsbece154b_bpred_gshare_ras_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ucsbece154b_bpred_gshare_ras_if #(.NUM_GHR_BITS(8), .RAS_DEPTH(8)) bp ();

    ucsbece154b_bpred_gshare_ras #(
        .NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(8), .RAS_DEPTH(8), .MODE(1)
    ) dut (
        .clk     (clk),
        .reset_i (rst_n),
        .bp      (bp)
    );

    typedef struct {
        string       name;
        bit          taken;
        logic [31:0] target;
        logic [7:0]  ghr;
        logic [3:0]  rp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: BTB keyed by slot holding the full trained PC,
    // counters as integers 0..3, history as an integer, RAS as a bounded queue.
    bit          m_v  [32];
    logic [31:0] m_pc [32];
    logic [31:0] m_tg [32];
    int          m_ty [32];
    int          m_pht[256];
    int          m_ghr;
    logic [31:0] m_ras[$];

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_v[i] = 0;
        for (int i = 0; i < 256; i++) m_pht[i] = 1;
        m_ghr = 0;
        m_ras.delete();
    endfunction

    function automatic void ras_push(input logic [31:0] a);
        if (m_ras.size() == 8) void'(m_ras.pop_front());
        m_ras.push_back(a);
    endfunction

    function automatic void ras_pop();
        if (m_ras.size() > 0) void'(m_ras.pop_back());
    endfunction

    function automatic void predict(input logic [31:0] pc, output bit hit, output int ty,
                                    output bit tk, output logic [31:0] tg);
        int i;
        int pi;
        i   = int'((pc >> 2) % 32);
        hit = m_v[i] && ((m_pc[i] >> 7) == (pc >> 7));
        ty  = m_ty[i];
        tk  = 0;
        tg  = 0;
        if (hit) begin
            if (ty == 0) begin
                pi = int'(((pc >> 2) ^ m_ghr) % 256);
                tk = (m_pht[pi] >= 2);
                tg = tk ? m_tg[i] : 32'd0;
            end else if (ty == 3) begin
                tk = 1;
                tg = (m_ras.size() > 0) ? m_ras[$] : m_tg[i];
            end else begin
                tk = 1;
                tg = m_tg[i];
            end
        end
    endfunction

    task automatic step(input string nm, input bit fv, input logic [31:0] fpc,
                        input bit uv, input logic [31:0] upc, input int uty, input bit utk,
                        input logic [31:0] utg, input int ughr, input int urp, input bit umis);
        bit hit;
        int ty;
        bit tk;
        logic [31:0] tg;
        exp_t e;
        int i;
        int pi;
        @(posedge clk); #1;
        rst_n             = 1'b1;
        bp.f_valid_i      = fv;
        bp.f_pc_i         = fpc;
        bp.u_valid_i      = uv;
        bp.u_pc_i         = upc;
        bp.u_type_i       = br_type_t'(uty[1:0]);
        bp.u_taken_i      = utk;
        bp.u_target_i     = utg;
        bp.u_ghr_i        = ughr[7:0];
        bp.u_rasptr_i     = urp[3:0];
        bp.u_mispredict_i = umis;
        predict(fpc, hit, ty, tk, tg);
        if (fv) begin
            e.name = nm; e.taken = tk; e.target = tg;
            e.ghr = m_ghr[7:0]; e.rp = 4'(m_ras.size());
            exp_q.push_back(e);
        end
        if (uv) begin
            i = int'((upc >> 2) % 32);
            if (utk || uty != 0) begin
                m_v[i] = 1; m_pc[i] = upc; m_ty[i] = uty; m_tg[i] = utg;
            end
            if (uty == 0) begin
                pi = int'(((upc >> 2) ^ ughr) % 256);
                if (utk) m_pht[pi] = (m_pht[pi] == 3) ? 3 : m_pht[pi] + 1;
                else     m_pht[pi] = (m_pht[pi] == 0) ? 0 : m_pht[pi] - 1;
            end
        end
        if (uv && umis) begin
            m_ghr = (uty == 0) ? (((ughr << 1) | int'(utk)) & 255) : (ughr & 255);
            while (m_ras.size() > urp) void'(m_ras.pop_back());
            if (uty == 2) ras_push(upc + 32'd4);
            if (uty == 3) ras_pop();
        end else if (fv && hit) begin
            if (ty == 0) m_ghr = ((m_ghr << 1) | int'(tk)) & 255;
            if (ty == 2) ras_push(fpc + 32'd4);
            if (ty == 3) ras_pop();
        end
    endtask

    task automatic fetch(input string nm, input logic [31:0] pc);
        step(nm, 1, pc, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic train(input logic [31:0] pc, input int ty, input bit tk, input logic [31:0] tg,
                         input int gh, input bit mis);
        step("", 0, 0, 1, pc, ty, tk, tg, gh, mis ? m_ras.size() : 0, mis);
    endtask

    task automatic do_reset(input int n, input bit burst);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            rst_n             = 1'b0;
            bp.f_valid_i      = 1'b0;
            bp.u_valid_i      = burst;
            bp.u_pc_i         = 32'h200 + 32'($urandom_range(0, 15)) * 4;
            bp.u_type_i       = br_type_t'($urandom_range(0, 3));
            bp.u_taken_i      = 1'b1;
            bp.u_target_i     = 32'h4000;
            bp.u_ghr_i        = 8'($urandom);
            bp.u_rasptr_i     = '0;
            bp.u_mispredict_i = 1'($urandom);
        end
        model_reset();
    endtask

    function automatic logic [31:0] rand_pc();
        case ($urandom_range(0, 5))
            0: rand_pc = 32'h200;
            1: rand_pc = 32'h300;
            2: rand_pc = 32'h840;
            3: rand_pc = 32'h1000 + 32'($urandom_range(0, 8)) * 4;
            4: rand_pc = 32'h2040;
            default: rand_pc = 32'($urandom_range(0, 1023)) << 2;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bp.f_valid_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_fetch: pc=%h with no expected entry", bp.f_pc_i);
            end else begin
                e = exp_q.pop_front();
                if (bp.f_taken_o !== e.taken || bp.f_target_o !== e.target ||
                    bp.f_ghr_o !== e.ghr || bp.f_rasptr_o !== e.rp) begin
                    failures++;
                    $display("FAIL %s: got taken=%0b target=%h ghr=%h rasptr=%0d, want taken=%0b target=%h ghr=%h rasptr=%0d",
                             e.name, bp.f_taken_o, bp.f_target_o, bp.f_ghr_o, bp.f_rasptr_o,
                             e.taken, e.target, e.ghr, e.rp);
                end
            end
        end
    end

    initial begin
        bp.f_valid_i = 0; bp.f_pc_i = 0; bp.u_valid_i = 0; bp.u_pc_i = 0;
        bp.u_type_i = BR_COND; bp.u_taken_i = 0; bp.u_target_i = 0;
        bp.u_ghr_i = 0; bp.u_rasptr_i = 0; bp.u_mispredict_i = 0;
        model_reset();
        do_reset(3, 0);

        fetch("t1_reset", 32'h100);

        // gshare: u_ghr=FF repairs history to FF, which is the trained index again.
        train(32'h200, 0, 1, 32'h180, 8'hFF, 1);
        train(32'h200, 0, 1, 32'h180, 8'hFF, 1);
        fetch("t2_taken", 32'h200);
        train(32'h200, 0, 0, 32'h180, 8'hFF, 0);
        train(32'h200, 0, 0, 32'h180, 8'hFF, 0);
        fetch("t2_not_taken", 32'h200);
        for (int k = 0; k < 4; k++) train(32'h200, 0, 1, 32'h180, 8'hFF, 1);
        train(32'h200, 0, 0, 32'h180, 8'hFF, 0);
        fetch("t2_sat_high", 32'h200);
        for (int k = 0; k < 4; k++) train(32'h200, 0, 0, 32'h180, 8'hFF, 0);
        train(32'h200, 0, 1, 32'h180, 8'hFF, 0);
        fetch("t2_sat_low", 32'h200);

        train(32'h300, 2, 1, 32'h800, 0, 0);
        train(32'h840, 3, 1, 32'h1234, 0, 0);
        fetch("t3_call", 32'h300);
        fetch("t3_ret", 32'h840);

        for (int k = 0; k < 9; k++) train(32'h1000 + 32'(k) * 4, 2, 1, 32'h3000, 0, 0);
        train(32'h2040, 3, 1, 32'hABC0, 0, 0);
        for (int k = 0; k < 9; k++) fetch("t4_call", 32'h1000 + 32'(k) * 4);
        for (int k = 0; k < 10; k++) fetch("t4_ret", 32'h2040);
        fetch("t4_ptr_empty", 32'h5000);

        fetch("t5_setup", 32'h1000);
        fetch("t5_setup", 32'h1004);
        step("t5_coincident", 1, 32'h1008, 1, 32'h200, 0, 1, 32'h180, 8'h5A, 1, 1);
        fetch("t5_after_repair", 32'h5000);

        do_reset(4, 1);
        fetch("t6_miss", 32'h200);
        fetch("t6_miss", 32'h840);
        fetch("t6_miss", 32'h1004);
        fetch("t6_miss", 32'h2040);
        train(32'h200, 0, 1, 32'h180, 0, 0);
        train(32'h200, 0, 0, 32'h180, 0, 0);
        fetch("t6_pht_reset", 32'h200);

        for (int k = 0; k < 400; k++) begin
            int uty;
            bit utk;
            bit mis;
            uty = $urandom_range(0, 3);
            utk = (uty != 0) ? 1'b1 : 1'($urandom);
            mis = ($urandom_range(0, 7) == 0);
            step("rand", 1'($urandom), rand_pc(), 1'($urandom), rand_pc(), uty, utk,
                 32'($urandom) & 32'hFFFF_FFFC, int'($urandom_range(0, 255)),
                 int'($urandom_range(m_ras.size(), 0)), mis);
        end

        @(posedge clk); #1;
        bp.f_valid_i = 0; bp.u_valid_i = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected responses never observed, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
